instruction_fetch_unit: RTL and testbench

Parametrised instruction fetch stage for the single-cycle datapath. It holds a writable instruction memory of `DEPTH = 2**ADDR_WIDTH` words and streams a program of `prog_len` words to the decode/execute stage over a registered valid/ready interface. It adds what the first-generation fetch block lacked: runtime program loading, backpressure, branch redirect, and halt-or-wrap at end of program. It sits between the program loader (testbench or boot logic) and the register-file/ALU decode path.

---
 rtl/instruction_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: writable program memory streamed to decode over a
// registered valid/ready interface, with branch redirect and halt-or-wrap at end of program.
module instruction_fetch_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int WRAP       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  control,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    input  logic [ADDR_WIDTH:0]   prog_len,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted,
    output logic [1:0]            state
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH + 1)'(1);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_FETCH = 2'b01;
    localparam logic [1:0] S_HALT  = 2'b10;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH:0]   fetch_ptr_q, fetch_ptr_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic                  slot_free;

    // Program memory is not reset; loads are only honoured while not streaming.
    always_ff @(posedge clk) begin
        if (prog_we && (state_q != S_FETCH)) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        fetch_ptr_d = fetch_ptr_q;
        len_d       = len_q;
        slot_free   = !valid_q || instr_ready;

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (control && (prog_len != '0)) begin
                    len_d       = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
                    fetch_ptr_d = '0;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                // Redirect wins over loading; an unaccepted held word is squashed.
                if (redirect) begin
                    valid_d     = 1'b0;
                    fetch_ptr_d = {1'b0, redirect_target};
                end else if (slot_free) begin
                    if (fetch_ptr_q >= len_q) begin
                        if (WRAP != 0) begin
                            if (control) begin
                                instr_d     = mem[0];
                                pc_d        = '0;
                                valid_d     = 1'b1;
                                fetch_ptr_d = ONE_W;
                            end else begin
                                valid_d = 1'b0;
                            end
                        end else begin
                            valid_d = 1'b0;
                            state_d = S_HALT;
                        end
                    end else if (control) begin
                        instr_d     = mem[fetch_ptr_q[ADDR_WIDTH-1:0]];
                        pc_d        = fetch_ptr_q[ADDR_WIDTH-1:0];
                        valid_d     = 1'b1;
                        fetch_ptr_d = fetch_ptr_q + ONE_W;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            S_HALT: begin
                valid_d = 1'b0;
                if (!control) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            fetch_ptr_q <= '0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            fetch_ptr_q <= fetch_ptr_d;
            len_q       <= len_d;
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign halted      = (state_q == S_HALT);
    assign state       = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a halting instance and a wrapping
// instance share clock, reset, program data and the consumer-side inputs.
module tb_instruction_fetch_unit;

    typedef struct packed {
        logic [2:0]  pc;
        logic [31:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        control0 = 1'b0, control1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [2:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic [3:0]  prog_len = '0;
    logic        redirect = 1'b0;
    logic [2:0]  redirect_target = '0;
    logic        ready = 1'b0;

    logic [31:0] instr0, instr1;
    logic        valid0, valid1;
    logic [2:0]  pc0, pc1;
    logic        halted0, halted1;
    logic [1:0]  state0, state1;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t e;
    logic [31:0] prog [6];

    always #5 clk = ~clk;

    instruction_fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .WRAP(0)) dut0 (
        .clk(clk), .reset(reset), .control(control0),
        .prog_we(we0), .prog_addr(prog_addr), .prog_data(prog_data), .prog_len(prog_len),
        .redirect(redirect), .redirect_target(redirect_target), .instr_ready(ready),
        .instruction(instr0), .instr_valid(valid0), .pc(pc0), .halted(halted0), .state(state0)
    );

    instruction_fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .WRAP(1)) dut1 (
        .clk(clk), .reset(reset), .control(control1),
        .prog_we(we1), .prog_addr(prog_addr), .prog_data(prog_data), .prog_len(prog_len),
        .redirect(1'b0), .redirect_target(3'd0), .instr_ready(ready),
        .instruction(instr1), .instr_valid(valid1), .pc(pc1), .halted(halted1), .state(state1)
    );

    task automatic push_seq(input int first, input int last);
        exp_t x;
        for (int i = first; i <= last; i++) begin
            x.pc  = 3'(i);
            x.ins = prog[i];
            q.push_back(x);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        control0 = 1'b0;
        control1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_program();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            we0 = 1'b1;
            we1 = 1'b1;
            prog_addr = 3'(i);
            prog_data = prog[i];
        end
        @(negedge clk);
        we0 = 1'b0;
        we1 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (state0 !== 2'b00 || pc0 !== 3'd0 || instr0 !== 32'd0 || valid0 !== 1'b0 || halted0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_dut0 state=%b pc=%0d instr=%h valid=%b halted=%b required 00/0/0/0/0",
                     state0, pc0, instr0, valid0, halted0);
        end
        checks++;
        if (state1 !== 2'b00 || valid1 !== 1'b0 || halted1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_dut1 state=%b valid=%b halted=%b required 00/0/0", state1, valid1, halted1);
        end
        reset = 1'b0;
    endtask

    task automatic test_prog_len_zero();
        @(negedge clk);
        prog_len = 4'd0;
        control0 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (state0 !== 2'b00 || valid0 !== 1'b0) begin
            failures++;
            $display("FAIL len_zero state=%b valid=%b required 00/0", state0, valid0);
        end
        control0 = 1'b0;
    endtask

    task automatic check_halt(input string name);
        @(negedge clk);
        checks++;
        if (valid0 !== 1'b0 || state0 !== 2'b10 || halted0 !== 1'b1) begin
            failures++;
            $display("FAIL %s valid=%b state=%b halted=%b required 0/10/1", name, valid0, state0, halted0);
        end
        control0 = 1'b0;
        @(negedge clk);
        checks++;
        if (state0 !== 2'b00) begin
            failures++;
            $display("FAIL %s_to_idle state=%b required 00", name, state0);
        end
    endtask

    task automatic test_basic_run();
        int first_cyc = -1, last_cyc = -1, cyc = 0;
        push_seq(0, 5);
        @(negedge clk);
        prog_len = 4'd6;
        ready = 1'b1;
        control0 = 1'b1;
        while (q.size() > 0 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (valid0 && ready) begin
                e = q.pop_front();
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                checks++;
                if (pc0 !== e.pc || instr0 !== e.ins) begin
                    failures++;
                    $display("FAIL basic_word pc=%0d instr=%h required pc=%0d instr=%h", pc0, instr0, e.pc, e.ins);
                end
            end
        end
        checks++;
        if (q.size() != 0 || last_cyc - first_cyc != 5) begin
            failures++;
            $display("FAIL basic_throughput left=%0d span=%0d required left=0 span=5", q.size(), last_cyc - first_cyc);
            q.delete();
        end
        check_halt("basic_halt");
    endtask

    task automatic test_backpressure_redirect();
        int stall = 0, cyc = 0;
        bit redir_done = 0, bubble_chk = 0;
        push_seq(0, 3);
        push_seq(1, 5);
        @(negedge clk);
        prog_len = 4'd6;
        ready = 1'b1;
        control0 = 1'b1;
        while (q.size() > 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            redirect = 1'b0;
            ready = 1'b1;
            if (bubble_chk) begin
                bubble_chk = 0;
                checks++;
                if (valid0 !== 1'b0) begin
                    failures++;
                    $display("FAIL redirect_bubble valid=%b required 0", valid0);
                end
            end
            if (valid0 && pc0 == 3'd2 && stall < 3) begin
                ready = 1'b0;
                stall++;
                checks++;
                if (instr0 !== prog[2]) begin
                    failures++;
                    $display("FAIL stall_hold instr=%h required %h", instr0, prog[2]);
                end
            end
            if (valid0 && pc0 == 3'd4 && !redir_done) begin
                ready = 1'b0;
                redirect = 1'b1;
                redirect_target = 3'd1;
                redir_done = 1;
                bubble_chk = 1;
            end
            if (valid0 && ready) begin
                e = q.pop_front();
                checks++;
                if (pc0 !== e.pc || instr0 !== e.ins) begin
                    failures++;
                    $display("FAIL bp_redirect_word pc=%0d instr=%h required pc=%0d instr=%h", pc0, instr0, e.pc, e.ins);
                end
            end
        end
        redirect = 1'b0;
        checks++;
        if (q.size() != 0 || stall != 3 || !redir_done) begin
            failures++;
            $display("FAIL bp_redirect_timeout left=%0d stalls=%0d required left=0 stalls=3", q.size(), stall);
            q.delete();
        end
        check_halt("bp_halt");
    endtask

    task automatic test_reset_mid_run();
        int cyc = 0;
        @(negedge clk);
        prog_len = 4'd6;
        ready = 1'b1;
        control0 = 1'b1;
        while (!(valid0 && pc0 == 3'd3) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (valid0 !== 1'b0 || pc0 !== 3'd0 || instr0 !== 32'd0 || state0 !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset valid=%b pc=%0d instr=%h state=%b required 0/0/0/00", valid0, pc0, instr0, state0);
        end
        reset = 1'b0;
        push_seq(0, 0);
        cyc = 0;
        while (q.size() > 0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (valid0 && ready) begin
                e = q.pop_front();
                control0 = 1'b0;
                checks++;
                if (pc0 !== e.pc || instr0 !== e.ins) begin
                    failures++;
                    $display("FAIL restart_word pc=%0d instr=%h required pc=%0d instr=%h", pc0, instr0, e.pc, e.ins);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL restart_timeout left=%0d required 0", q.size());
            q.delete();
        end
        do_reset();
    endtask

    task automatic test_we_during_fetch();
        int cyc = 0;
        push_seq(0, 5);
        @(negedge clk);
        prog_len = 4'd6;
        ready = 1'b1;
        control0 = 1'b1;
        @(negedge clk);
        we0 = 1'b1;
        prog_addr = 3'd2;
        prog_data = 32'hDEADBEEF;
        while (q.size() > 0 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            we0 = 1'b0;
            if (valid0 && ready) begin
                e = q.pop_front();
                checks++;
                if (pc0 !== e.pc || instr0 !== e.ins) begin
                    failures++;
                    $display("FAIL we_fetch_word pc=%0d instr=%h required pc=%0d instr=%h", pc0, instr0, e.pc, e.ins);
                end
            end
        end
        we0 = 1'b0;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL we_fetch_timeout left=%0d required 0", q.size());
            q.delete();
        end
        check_halt("we_halt");
    endtask

    task automatic test_wrap();
        int cyc = 0;
        bit started = 0;
        push_seq(0, 2);
        push_seq(0, 2);
        push_seq(0, 0);
        @(negedge clk);
        prog_len = 4'd3;
        ready = 1'b1;
        control1 = 1'b1;
        while (q.size() > 0 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (started) begin
                checks++;
                if (valid1 !== 1'b1 || halted1 !== 1'b0) begin
                    failures++;
                    $display("FAIL wrap_bubble valid=%b halted=%b required 1/0", valid1, halted1);
                end
            end
            if (valid1 && ready) begin
                started = 1;
                e = q.pop_front();
                checks++;
                if (pc1 !== e.pc || instr1 !== e.ins) begin
                    failures++;
                    $display("FAIL wrap_word pc=%0d instr=%h required pc=%0d instr=%h", pc1, instr1, e.pc, e.ins);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL wrap_timeout left=%0d required 0", q.size());
            q.delete();
        end
        control1 = 1'b0;
    endtask

    initial begin
        prog[0] = 32'hC00A000A;
        prog[1] = 32'hC00F000F;
        prog[2] = 32'h414FC800;
        prog[3] = 32'hE3340005;
        prog[4] = 32'hC0050002;
        prog[5] = 32'h8325F000;
        test_reset();
        load_program();
        test_prog_len_zero();
        test_basic_run();
        test_backpressure_redirect();
        test_reset_mid_run();
        test_wrap();
        test_we_during_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
